// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer.
// Builds round keys rk[0..10] one per clock using a single round of four S-boxes.
// The keys are held in an internal register file and read through a registered port.

// Combinational AES S-box: multiplicative inverse in GF(2^8), then the affine map.
module sbox1 (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0)
  function automatic logic [7:0] f_ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = f_gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = f_gmul(sq, sq);
      acc = f_gmul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  // Inverse followed by the affine transform b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  always_comb begin
    w_inv = f_ginv(i_a);
    o_s   = w_inv
          ^ {w_inv[6:0], w_inv[7]}
          ^ {w_inv[5:0], w_inv[7:6]}
          ^ {w_inv[4:0], w_inv[7:5]}
          ^ {w_inv[3:0], w_inv[7:4]}
          ^ 8'h63;
  end

endmodule

module key_sched_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key,
  output logic          busy,
  output logic          done,
  output logic          key_valid,
  input  logic [3:0]    rd_round,
  output logic [KW-1:0] rd_key,
  output logic          rd_valid
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_rcon;
  logic          r_busy;
  logic          r_done;
  logic          r_key_valid;
  logic [KW-1:0] r_rk [0:NR];
  logic [KW-1:0] r_rd_key;
  logic          r_rd_valid;

  state_t        w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic [7:0]    w_rcon_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_kv_nxt;
  logic          w_we;
  logic [3:0]    w_wr_idx;
  logic [KW-1:0] w_wr_data;

  logic [KW-1:0] w_prev;
  logic [31:0]   w_p0, w_p1, w_p2, w_p3;
  logic [31:0]   w_rot;
  logic [7:0]    w_sb [4];
  logic [31:0]   w_t;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;
  logic [KW-1:0] w_next_rk;
  logic          w_rd_in_range;
  logic [KW-1:0] w_rd_sel;

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Select the previous round key rk[cnt-1] as the expansion source
  always_comb begin
    w_prev = '0;
    for (int i = 1; i <= NR; i++) begin
      if (r_cnt == 4'(i)) w_prev = r_rk[i-1];
    end
  end

  assign w_p0  = w_prev[127:96];
  assign w_p1  = w_prev[95:64];
  assign w_p2  = w_prev[63:32];
  assign w_p3  = w_prev[31:0];
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  sbox1 u_sb0 (.i_a(w_rot[31:24]), .o_s(w_sb[0]));
  sbox1 u_sb1 (.i_a(w_rot[23:16]), .o_s(w_sb[1]));
  sbox1 u_sb2 (.i_a(w_rot[15:8]),  .o_s(w_sb[2]));
  sbox1 u_sb3 (.i_a(w_rot[7:0]),   .o_s(w_sb[3]));

  assign w_t       = {w_sb[0] ^ r_rcon, w_sb[1], w_sb[2], w_sb[3]};
  assign w_n0      = w_p0 ^ w_t;
  assign w_n1      = w_p1 ^ w_n0;
  assign w_n2      = w_p2 ^ w_n1;
  assign w_n3      = w_p3 ^ w_n2;
  assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

  // Next-state, control and register-file write decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rcon_nxt  = r_rcon;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_kv_nxt    = r_key_valid;
    w_we        = 1'b0;
    w_wr_idx    = 4'd0;
    w_wr_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_EXPAND;
          w_cnt_nxt   = 4'd1;
          w_rcon_nxt  = 8'h01;
          w_kv_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_we        = 1'b1;
          w_wr_idx    = 4'd0;
          w_wr_data   = key;
        end
      end
      S_EXPAND: begin
        w_we       = 1'b1;
        w_wr_idx   = r_cnt;
        w_wr_data  = w_next_rk;
        w_rcon_nxt = f_xtime(r_rcon);
        w_cnt_nxt  = r_cnt + 4'd1;
        if (r_cnt == LAST) begin
          // Last round key written: counter parks at 0 so it never exceeds NR
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_kv_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rcon      <= 8'h01;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rcon      <= w_rcon_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_key_valid <= w_kv_nxt;
    end
  end

  // Round-key register file, one entry written per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (w_we && (w_wr_idx == 4'(i))) r_rk[i] <= w_wr_data;
      end
    end
  end

  // Read mux; a key being written this edge is forwarded so that rd_valid
  // rising with the final write never pairs with a stale rk[10]
  always_comb begin
    w_rd_in_range = (rd_round <= LAST);
    w_rd_sel      = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_round == 4'(i)) w_rd_sel = r_rk[i];
    end
    if (w_we && (w_wr_idx == rd_round)) w_rd_sel = w_wr_data;
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_key   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_key   <= w_rd_in_range ? w_rd_sel : '0;
      r_rd_valid <= w_kv_nxt & w_rd_in_range;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign key_valid = r_key_valid;
  assign rd_key    = r_rd_key;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed and random bench for key_sched_ctrl.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;

  int checks;
  int failures;

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_SEQ10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0]   rcon_t [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};
  logic [127:0] ref_rk [11];

  key_sched_ctrl #(.NR(10), .KW(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_round  (rd_round),
    .rd_key    (rd_key),
    .rd_valid  (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook word-oriented AES-128 key expansion
  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] r, output logic [127:0] k, output logic v);
    rd_round = r;
    step();
    k = rd_key;
    v = rd_valid;
  endtask

  // Pulse start for one cycle, then wait (bounded) for busy to fall
  task automatic run_exp(input logic [127:0] k, output int n, output logic d);
    start = 1'b1;
    key   = k;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    d = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key = '0; rd_round = 4'd0;
    #3;
    checks++;
    if ({busy, done, key_valid, rd_valid} !== 4'b0000 || rd_key !== 128'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b kv=%b rv=%b rd_key=%h, need all 0",
               busy, done, key_valid, rd_valid, rd_key);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    checks++;
    if ({busy, done, rd_valid} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b rv=%b, need 000", busy, done, rd_valid);
    end
  endtask

  task automatic test_fips();
    int n; logic d; logic [127:0] k; logic v;
    run_exp(K_FIPS, n, d);
    checks++;
    if (n !== 10) begin failures++; $display("FAIL fips_busy_len: got %0d need 10", n); end
    checks++;
    if (d !== 1'b1 || key_valid !== 1'b1) begin
      failures++; $display("FAIL fips_done: done=%b kv=%b need 1 1", d, key_valid);
    end
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL fips_done_pulse: done=%b need 0", done); end
    do_read(4'd1, k, v);
    checks++;
    if (k !== K_FIPS1 || v !== 1'b1) begin
      failures++; $display("FAIL fips_rk1: got %h v=%b need %h v=1", k, v, K_FIPS1);
    end
    do_read(4'd10, k, v);
    checks++;
    if (k !== K_FIPS10 || v !== 1'b1) begin
      failures++; $display("FAIL fips_rk10: got %h v=%b need %h v=1", k, v, K_FIPS10);
    end
    do_read(4'd0, k, v);
    checks++;
    if (k !== K_FIPS || v !== 1'b1) begin
      failures++; $display("FAIL fips_rk0: got %h v=%b need %h v=1", k, v, K_FIPS);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [127:0] k; logic v;
    start = 1'b1; key = K_SEQ; rd_round = 4'd10;
    step();
    key = K_FIPS;
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n !== 10 || done !== 1'b1) begin
      failures++; $display("FAIL held_first_run: len=%0d done=%b need 10 1", n, done);
    end
    step();
    checks++;
    if (busy !== 1'b1 || key_valid !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b kv=%b rv=%b need 1 0 0", busy, key_valid, rd_valid);
    end
    checks++;
    if (rd_key !== K_SEQ10) begin
      failures++; $display("FAIL held_first_rk10: got %h need %h", rd_key, K_SEQ10);
    end
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n !== 10 || done !== 1'b1) begin
      failures++; $display("FAIL b2b_second_run: len=%0d done=%b need 10 1", n, done);
    end
    do_read(4'd10, k, v);
    checks++;
    if (k !== K_FIPS10 || v !== 1'b1) begin
      failures++; $display("FAIL b2b_rk10: got %h v=%b need %h v=1", k, v, K_FIPS10);
    end
    do_read(4'd0, k, v);
    checks++;
    if (k !== K_FIPS || v !== 1'b1) begin
      failures++; $display("FAIL b2b_rk0: got %h v=%b need %h v=1", k, v, K_FIPS);
    end
  endtask

  task automatic test_out_of_range();
    int n; logic [127:0] k; logic v;
    do_read(4'd11, k, v);
    checks++;
    if (k !== 128'h0 || v !== 1'b0) begin
      failures++; $display("FAIL oor_11: got %h v=%b need 0 v=0", k, v);
    end
    do_read(4'd15, k, v);
    checks++;
    if (k !== 128'h0 || v !== 1'b0) begin
      failures++; $display("FAIL oor_15: got %h v=%b need 0 v=0", k, v);
    end
    start = 1'b1; key = K_SEQ; rd_round = 4'd3;
    step();
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL read_during_expand: busy=%b rv=%b need 1 0", busy, rd_valid);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL oor_run_done: done=%b need 1", done); end
  endtask

  task automatic test_reset_mid();
    int n; logic d; logic [127:0] k; logic v;
    start = 1'b1; key = K_SEQ; rd_round = 4'd1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, key_valid, rd_valid} !== 4'b0000 || rd_key !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b kv=%b rv=%b rd_key=%h need all 0",
               busy, done, key_valid, rd_valid, rd_key);
    end
    step();
    rst_n = 1'b1;
    do_read(4'd1, k, v);
    checks++;
    if (k !== 128'h0 || v !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_rk_clear: got %h v=%b busy=%b need 0 0 0", k, v, busy);
    end
    run_exp(128'h0, n, d);
    checks++;
    if (n !== 10 || d !== 1'b1) begin
      failures++; $display("FAIL zero_run: len=%0d done=%b need 10 1", n, d);
    end
    do_read(4'd10, k, v);
    checks++;
    if (k !== K_ZERO10 || v !== 1'b1) begin
      failures++; $display("FAIL zero_rk10: got %h v=%b need %h v=1", k, v, K_ZERO10);
    end
  endtask

  task automatic test_random();
    int n; logic d; logic [127:0] k; logic [127:0] kr; logic v;
    for (int it = 0; it < 200; it++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      compute_ref(kr);
      run_exp(kr, n, d);
      checks++;
      if (n !== 10 || d !== 1'b1) begin
        failures++; $display("FAIL rand_run[%0d]: len=%0d done=%b need 10 1", it, n, d);
      end
      for (int r = 0; r < 11; r++) begin
        do_read(4'(r), k, v);
        checks++;
        if (k !== ref_rk[r] || v !== 1'b1) begin
          failures++;
          $display("FAIL rand_rk[%0d][%0d]: got %h v=%b need %h v=1", it, r, k, v, ref_rk[r]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fips();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
